// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, datapath widths and the
// instruction-buffer entry layout {pc, instr}.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and decode. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking for all state so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; entries are only observed through a valid pointer range.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential imem requests, buffers responses for decode,
// and squashes in-flight work on redirect. Define FETCH_PERF_EN for perf counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [ILEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;

    logic [CW:0]     inflight;
    logic            req_valid, req_fire;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_in, fifo_head;

    assign fifo_in = '{pc: pc_resp_pc(), instr: imem_rsp_data_i};

    // Each response belongs to the oldest request: its pc is the fetch pc minus
    // four per request still in flight (requests advance pc in order).
    function automatic logic [XLEN-1:0] pc_resp_pc();
        return pc_q - {{(XLEN-CW-2){1'b0}}, outstanding_q, 2'b00};
    endfunction

    always_comb begin
        inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req_valid = (state_q == ST_FETCH) && (inflight < DEPTH_LIM) && !fifo_full
                    && !redirect_valid_i;
        req_fire  = req_valid && imem_req_ready_i;

        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;

        if (req_fire) begin
            pc_d          = pc_q + 64'd4;
            outstanding_d = outstanding_q + CNT_ONE;
        end
        if (imem_rsp_valid_i) outstanding_d = outstanding_d - CNT_ONE;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (redirect_valid_i) pc_d = redirect_pc_i;
            end
            ST_FETCH: begin
                if (redirect_valid_i) begin
                    fifo_flush = 1'b1;
                    pc_d       = redirect_pc_i;
                    state_d    = (outstanding_d != '0) ? ST_FLUSH : ST_FETCH;
                end else begin
                    fifo_push = imem_rsp_valid_i;
                    fifo_pop  = !fifo_empty && id_ready_i;
                end
            end
            ST_FLUSH: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (outstanding_d == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_data_i(fifo_in),
        .pop_i      (fifo_pop),
        .flush_i    (fifo_flush),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;
    assign id_valid_o       = !fifo_empty;
    assign id_instr_o       = fifo_empty ? '0 : fifo_head.instr;
    assign id_pc_o          = fifo_empty ? '0 : fifo_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, fifo_pop};
        perf_flush_d = perf_flush_q + {31'd0, redirect_valid_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
